// File: rtl/mem_map_pkg.sv
// Address map, MMIO offsets and region tags shared by the data SRAM responder.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mem_map_pkg;

    localparam logic [31:0] RAM_BASE_DEFAULT  = 32'h8000_0000;
    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hA000_0000;
    localparam logic [31:0] BAD_RDATA_DEFAULT = 32'hDEAD_BEEF;

    localparam logic [3:0] MMIO_CONSOLE  = 4'h0;
    localparam logic [3:0] MMIO_TIMER_LO = 4'h8;
    localparam logic [3:0] MMIO_TIMER_HI = 4'hC;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_MMIO,
        REGION_NONE
    } region_e;

endpackage

// File: rtl/sram_bank.sv
// Word-wide synchronous RAM with per-byte write enables; contents are never reset.
// Latency: read data registered, valid one cycle after idx is presented.
// Backpressure: none, accepts one access every cycle.
module sram_bank #(
    parameter int WORDS = 4096
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [3:0]               wmask,
    input  logic [$clog2(WORDS)-1:0] idx,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        // Read-before-write: a same-cycle write is visible on the following read.
        rdata <= mem[idx];
    end

endmodule

// File: rtl/data_sram_responder.sv
// Data SRAM port target: byte-masked RAM, console register, 64-bit timer, sticky unmapped-access capture.
// Latency: read data one cycle after the request; otherwise the last value is held.
// Backpressure: none, one request accepted every cycle.
module data_sram_responder
    import mem_map_pkg::*;
#(
    parameter logic [31:0] RAM_BASE  = RAM_BASE_DEFAULT,
    parameter int          RAM_WORDS = 4096,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT,
    parameter logic [31:0] BAD_RDATA = BAD_RDATA_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic        data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    input  logic [3:0]  data_sram_wmask,
    output logic [31:0] data_sram_rdata,
    output logic        console_valid,
    output logic [7:0]  console_char,
    output logic        bad_access,
    output logic [31:0] bad_addr
);

    localparam int          IW      = $clog2(RAM_WORDS);
    localparam logic [32:0] RAM_END = {1'b0, RAM_BASE} + 33'(RAM_WORDS) * 33'd4;

    region_e     region;
    region_e     rd_tag_q;
    logic [3:0]  mmio_off;
    logic [31:0] rd_word;
    logic [31:0] rd_hold_q;
    logic [31:0] ram_rdata;
    logic [IW-1:0] ram_idx;
    logic [63:0] timer_q;
    logic [31:0] timer_hi_q;
    logic        req_rd;
    logic        req_wr;
    logic        ram_we;
    logic        lo_rd;
    logic        con_wr;
    logic        bad_req;

    assign req_rd   = data_sram_en & ~data_sram_wen;
    assign req_wr   = data_sram_en &  data_sram_wen;
    assign mmio_off = {data_sram_addr[3:2], 2'b00};
    assign ram_idx  = data_sram_addr[IW+1:2] - RAM_BASE[IW+1:2];

    always_comb begin
        region = REGION_NONE;
        if ({1'b0, data_sram_addr} >= {1'b0, RAM_BASE} && {1'b0, data_sram_addr} < RAM_END) begin
            region = REGION_RAM;
        end else if (data_sram_addr[31:4] == MMIO_BASE[31:4] && mmio_off != 4'h4) begin
            region = REGION_MMIO;
        end
    end

    always_comb begin
        rd_word = BAD_RDATA;
        if (region == REGION_MMIO) begin
            case (mmio_off)
                MMIO_CONSOLE:  rd_word = 32'h0;
                MMIO_TIMER_LO: rd_word = timer_q[31:0];
                MMIO_TIMER_HI: rd_word = timer_hi_q;
                default:       rd_word = BAD_RDATA;
            endcase
        end
    end

    assign ram_we  = req_wr & (region == REGION_RAM) & ~reset;
    assign lo_rd   = req_rd & (region == REGION_MMIO) & (mmio_off == MMIO_TIMER_LO);
    assign con_wr  = req_wr & (region == REGION_MMIO) & (mmio_off == MMIO_CONSOLE) & data_sram_wmask[0];
    assign bad_req = data_sram_en & (region == REGION_NONE);

    sram_bank #(
        .WORDS (RAM_WORDS)
    ) u_bank (
        .clk   (clk),
        .we    (ram_we),
        .wmask (data_sram_wmask),
        .idx   (ram_idx),
        .wdata (data_sram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q       <= 64'h0;
            timer_hi_q    <= 32'h0;
            rd_tag_q      <= REGION_NONE;
            rd_hold_q     <= 32'h0;
            console_valid <= 1'b0;
            console_char  <= 8'h0;
            bad_access    <= 1'b0;
            bad_addr      <= 32'h0;
        end else begin
            timer_q       <= timer_q + 64'd1;
            console_valid <= con_wr;
            if (lo_rd) begin
                timer_hi_q <= timer_q[63:32];
            end
            if (con_wr) begin
                console_char <= data_sram_wdata[7:0];
            end
            if (bad_req) begin
                bad_access <= 1'b1;
                if (!bad_access) begin
                    bad_addr <= data_sram_addr;
                end
            end
            // The bank output moves every cycle, so non-read cycles freeze the visible word here.
            if (req_rd) begin
                rd_tag_q  <= region;
                rd_hold_q <= rd_word;
            end else begin
                rd_tag_q  <= REGION_NONE;
                rd_hold_q <= data_sram_rdata;
            end
        end
    end

    assign data_sram_rdata = (rd_tag_q == REGION_RAM) ? ram_rdata : rd_hold_q;

endmodule
